// File: rtl/vip_in_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vip_in_buffer_pkg
// Description : Shared image dimensions, channel count and position-tag type
//               for the VGG16 pixel input path.
// Revision    : 1.0 - initial release
// ============================================================================
package vip_in_buffer_pkg;

    // Image geometry shared across the pipeline stages
    localparam int c_IMG_WIDTH  = 224;
    localparam int c_IMG_HEIGHT = 224;
    localparam int c_NUM_IMG    = 1;

    // Channel words carried per pixel
    localparam int c_NUM_CH     = 8;

    // Frame-position tags attached to the head pixel
    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pos_tags_t;

    // Counter width that stays legal for a dimension of 1
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vip_pos_counter.sv
`default_nettype none
// ============================================================================
// Module      : vip_pos_counter
// Description : Column/row tracker for a pixel stream with start-of-frame,
//               end-of-line and end-of-frame decode. Advances on each
//               accepted pixel; tags are gated by the stream valid.
// Revision    : 1.0 - initial release
// ============================================================================
module vip_pos_counter
    import vip_in_buffer_pkg::*;
#(
    parameter int WIDTH  = c_IMG_WIDTH,
    parameter int HEIGHT = c_IMG_HEIGHT
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      advance,
    input  logic      valid,
    output pos_tags_t tags
);

    localparam int c_CW = cnt_w(WIDTH);
    localparam int c_RW = cnt_w(HEIGHT);

    logic [c_CW-1:0] r_col;
    logic [c_RW-1:0] r_row;
    logic            w_last_col;
    logic            w_last_row;

    assign w_last_col = (r_col == c_CW'(WIDTH - 1));
    assign w_last_row = (r_row == c_RW'(HEIGHT - 1));

    // Step col/row on every consumed pixel; full wrap after the last pixel of a frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (advance) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + c_RW'(1);
            end else begin
                r_col <= r_col + c_CW'(1);
            end
        end
    end

    // Position decode of the current head pixel
    always_comb begin
        tags.sof = valid && (r_col == '0) && (r_row == '0);
        tags.eol = valid && w_last_col;
        tags.eof = valid && w_last_col && w_last_row;
    end

endmodule
`default_nettype wire

// File: rtl/vip_in_buffer.sv
`default_nettype none
// ============================================================================
// Module      : vip_in_buffer
// Description : Receive buffer for the 8-channel pixel write interface.
//               First-word-fall-through FIFO with registered full flag,
//               sticky overflow and frame-position tagging on the output.
// Revision    : 1.0 - initial release
// ============================================================================
module vip_in_buffer
    import vip_in_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int WIDTH      = c_IMG_WIDTH,
    parameter int HEIGHT     = c_IMG_HEIGHT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   fifo_in_data_0,
    input  logic [DATA_WIDTH-1:0]   fifo_in_data_1,
    input  logic [DATA_WIDTH-1:0]   fifo_in_data_2,
    input  logic [DATA_WIDTH-1:0]   fifo_in_data_3,
    input  logic [DATA_WIDTH-1:0]   fifo_in_data_4,
    input  logic [DATA_WIDTH-1:0]   fifo_in_data_5,
    input  logic [DATA_WIDTH-1:0]   fifo_in_data_6,
    input  logic [DATA_WIDTH-1:0]   fifo_in_data_7,
    input  logic                    fifo_in_wrreq,
    output logic                    fifo_in_full,
    output logic [DATA_WIDTH-1:0]   out_data_0,
    output logic [DATA_WIDTH-1:0]   out_data_1,
    output logic [DATA_WIDTH-1:0]   out_data_2,
    output logic [DATA_WIDTH-1:0]   out_data_3,
    output logic [DATA_WIDTH-1:0]   out_data_4,
    output logic [DATA_WIDTH-1:0]   out_data_5,
    output logic [DATA_WIDTH-1:0]   out_data_6,
    output logic [DATA_WIDTH-1:0]   out_data_7,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sof,
    output logic                    out_eol,
    output logic                    out_eof,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow
);

    localparam int c_AW     = $clog2(DEPTH);
    localparam int c_LW     = c_AW + 1;
    localparam int c_WORD_W = c_NUM_CH * DATA_WIDTH;

    logic [c_WORD_W-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_LW-1:0]       r_level;
    logic [c_LW-1:0]       w_level_nxt;
    logic                  r_full;
    logic                  r_overflow;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_valid;
    logic [DATA_WIDTH-1:0] w_in_ch [c_NUM_CH];
    logic [c_WORD_W-1:0]   w_wr_word;
    logic [c_WORD_W-1:0]   w_rd_word;
    pos_tags_t             w_tags;

    assign w_in_ch[0] = fifo_in_data_0;
    assign w_in_ch[1] = fifo_in_data_1;
    assign w_in_ch[2] = fifo_in_data_2;
    assign w_in_ch[3] = fifo_in_data_3;
    assign w_in_ch[4] = fifo_in_data_4;
    assign w_in_ch[5] = fifo_in_data_5;
    assign w_in_ch[6] = fifo_in_data_6;
    assign w_in_ch[7] = fifo_in_data_7;

    // Channel 0 occupies the low word of an entry
    for (genvar g = 0; g < c_NUM_CH; g++) begin : g_pack
        assign w_wr_word[g*DATA_WIDTH +: DATA_WIDTH] = w_in_ch[g];
    end

    // Full is registered, so a push in the same cycle as a pop at DEPTH is refused
    assign w_valid = (r_level != '0);
    assign w_push  = fifo_in_wrreq && !r_full;
    assign w_pop   = w_valid && out_ready;

    // Occupancy after this edge; simultaneous push and pop cancel
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + c_LW'(1);
            2'b01:   w_level_nxt = r_level - c_LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Pointer, occupancy and flag state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == c_LW'(DEPTH));
            if (fifo_in_wrreq && r_full) r_overflow <= 1'b1;
        end
    end

    // Storage is not reset; the read side is gated by valid instead
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_word;
    end

    assign w_rd_word = w_valid ? r_mem[r_rd_ptr] : '0;

    vip_pos_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pos (
        .clock   (clock),
        .reset   (reset),
        .advance (w_pop),
        .valid   (w_valid),
        .tags    (w_tags)
    );

    assign out_data_0   = w_rd_word[0*DATA_WIDTH +: DATA_WIDTH];
    assign out_data_1   = w_rd_word[1*DATA_WIDTH +: DATA_WIDTH];
    assign out_data_2   = w_rd_word[2*DATA_WIDTH +: DATA_WIDTH];
    assign out_data_3   = w_rd_word[3*DATA_WIDTH +: DATA_WIDTH];
    assign out_data_4   = w_rd_word[4*DATA_WIDTH +: DATA_WIDTH];
    assign out_data_5   = w_rd_word[5*DATA_WIDTH +: DATA_WIDTH];
    assign out_data_6   = w_rd_word[6*DATA_WIDTH +: DATA_WIDTH];
    assign out_data_7   = w_rd_word[7*DATA_WIDTH +: DATA_WIDTH];
    assign out_valid    = w_valid;
    assign out_sof      = w_tags.sof;
    assign out_eol      = w_tags.eol;
    assign out_eof      = w_tags.eof;
    assign fifo_in_full = r_full;
    assign level        = r_level;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_vip_in_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vip_in_buffer
// Description : Self-checking bench for vip_in_buffer with a queue-based
//               reference model of FIFO contents and frame position.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vip_in_buffer;

    localparam int c_DW    = 32;
    localparam int c_DEPTH = 16;
    localparam int c_W     = 4;
    localparam int c_H     = 3;
    localparam int c_LW    = 5;
    localparam int c_WW    = 8 * c_DW;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [c_DW-1:0]   din [8];
    logic              wrreq = 1'b0;
    logic              ready = 1'b0;
    logic              full;
    logic [c_DW-1:0]   dout [8];
    logic              out_valid;
    logic              out_sof;
    logic              out_eol;
    logic              out_eof;
    logic [c_LW-1:0]   level;
    logic              overflow;

    logic [c_WW-1:0]   cur_word = '0;
    logic [c_WW-1:0]   sb [$];
    int                pix = 0;
    bit                ov_m = 1'b0;
    int                checks = 0;
    int                failures = 0;

    vip_in_buffer #(
        .DATA_WIDTH (c_DW),
        .DEPTH      (c_DEPTH),
        .WIDTH      (c_W),
        .HEIGHT     (c_H)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .fifo_in_data_0 (din[0]),
        .fifo_in_data_1 (din[1]),
        .fifo_in_data_2 (din[2]),
        .fifo_in_data_3 (din[3]),
        .fifo_in_data_4 (din[4]),
        .fifo_in_data_5 (din[5]),
        .fifo_in_data_6 (din[6]),
        .fifo_in_data_7 (din[7]),
        .fifo_in_wrreq  (wrreq),
        .fifo_in_full   (full),
        .out_data_0     (dout[0]),
        .out_data_1     (dout[1]),
        .out_data_2     (dout[2]),
        .out_data_3     (dout[3]),
        .out_data_4     (dout[4]),
        .out_data_5     (dout[5]),
        .out_data_6     (dout[6]),
        .out_data_7     (dout[7]),
        .out_valid      (out_valid),
        .out_ready      (ready),
        .out_sof        (out_sof),
        .out_eol        (out_eol),
        .out_eof        (out_eof),
        .level          (level),
        .overflow       (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [c_WW-1:0] obs, input logic [c_WW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_WW-1:0] pix_word(input int k);
        logic [c_WW-1:0] w;
        for (int c = 0; c < 8; c++) w[c*c_DW +: c_DW] = c_DW'(k * 8 + c);
        return w;
    endfunction

    function automatic logic [c_WW-1:0] out_word();
        logic [c_WW-1:0] w;
        for (int c = 0; c < 8; c++) w[c*c_DW +: c_DW] = dout[c];
        return w;
    endfunction

    // Reference model: compare head and flags, then apply the pop/push the next edge will perform
    always @(negedge clock) begin
        int sz0;
        if (reset) begin
            sb.delete();
            pix  = 0;
            ov_m = 1'b0;
            check("rst_valid", c_WW'(out_valid), '0);
            check("rst_full",  c_WW'(full), '0);
            check("rst_level", c_WW'(level), '0);
            check("rst_tags",  c_WW'({out_sof, out_eol, out_eof}), '0);
            check("rst_data",  out_word(), '0);
            check("rst_ovf",   c_WW'(overflow), '0);
        end else begin
            sz0 = sb.size();
            check("valid", c_WW'(out_valid), c_WW'(sz0 != 0));
            check("level", c_WW'(level), c_WW'(sz0));
            check("full",  c_WW'(full), c_WW'(sz0 == c_DEPTH));
            check("ovf",   c_WW'(overflow), c_WW'(ov_m));
            if (sz0 != 0) begin
                check("data", out_word(), sb[0]);
                check("sof",  c_WW'(out_sof), c_WW'((pix % (c_W * c_H)) == 0));
                check("eol",  c_WW'(out_eol), c_WW'((pix % c_W) == c_W - 1));
                check("eof",  c_WW'(out_eof), c_WW'((pix % (c_W * c_H)) == c_W * c_H - 1));
                if (ready) begin
                    void'(sb.pop_front());
                    pix++;
                end
            end else begin
                check("idle_data", out_word(), '0);
                check("idle_tags", c_WW'({out_sof, out_eol, out_eof}), '0);
            end
            if (wrreq && sz0 == c_DEPTH) ov_m = 1'b1;
            if (wrreq && sz0 <  c_DEPTH) sb.push_back(cur_word);
        end
    end

    task automatic drive(input bit wr, input bit rdy, input int k);
        @(posedge clock);
        #1;
        wrreq    = wr;
        ready    = rdy;
        cur_word = pix_word(k);
        for (int c = 0; c < 8; c++) din[c] = cur_word[c*c_DW +: c_DW];
    endtask

    task automatic sample();
        @(negedge clock);
        #1;
    endtask

    initial begin
        int pushed;
        int cyc;
        for (int c = 0; c < 8; c++) din[c] = '0;

        // Reset held for three cycles with a write request pending
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 99);
        @(posedge clock);
        #1;
        reset = 1'b0;
        wrreq = 1'b0;
        drive(1'b1, 1'b0, 0);
        drive(1'b0, 1'b0, 0);
        sample();
        check("first_push_valid", c_WW'(out_valid), c_WW'(1));
        check("first_push_data",  out_word(), pix_word(0));
        drive(1'b0, 1'b1, 0);

        // Fill to DEPTH plus one rejected write
        for (int k = 1; k <= 17; k++) drive(1'b1, 1'b0, k);
        drive(1'b0, 1'b0, 0);
        sample();
        check("fill_full",  c_WW'(full), c_WW'(1));
        check("fill_level", c_WW'(level), c_WW'(16));
        check("fill_ovf",   c_WW'(overflow), c_WW'(1));

        // Drain in order
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 0);
        drive(1'b0, 1'b0, 0);
        sample();
        check("drain_empty", c_WW'(out_valid), '0);

        // Simultaneous push/pop while full
        for (int k = 100; k < 116; k++) drive(1'b1, 1'b0, k);
        drive(1'b1, 1'b1, 116);
        drive(1'b0, 1'b0, 0);
        sample();
        check("pp_full_level", c_WW'(level), c_WW'(15));

        // Simultaneous push/pop while empty
        for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, 0);
        drive(1'b1, 1'b1, 200);
        drive(1'b0, 1'b0, 0);
        sample();
        check("pp_empty_level", c_WW'(level), c_WW'(1));

        // Sustained push/pop at level 5
        for (int k = 201; k < 205; k++) drive(1'b1, 1'b0, k);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 205 + i);
            sample();
            check("pp_mid_level", c_WW'(level), c_WW'(5));
        end
        drive(1'b0, 1'b0, 0);

        // Frame tags over two 4x3 frames with random back-pressure
        @(posedge clock);
        #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 0);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        pushed = 0;
        cyc    = 0;
        while (pix < 24 && cyc < 2000) begin
            bit wr;
            wr = (pushed < 24) && ($urandom_range(0, 3) != 0);
            if (wr && !full) begin
                drive(1'b1, 1'($urandom_range(0, 1)), 300 + pushed);
                pushed++;
            end else begin
                drive(wr, 1'($urandom_range(0, 1)), 300 + pushed);
            end
            cyc++;
        end
        check("frame_pops", c_WW'(pix), c_WW'(24));
        drive(1'b0, 1'b0, 0);

        // Reset in the middle of a frame
        for (int k = 500; k < 508; k++) drive(1'b1, 1'b0, k);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        wrreq = 1'b0;
        ready = 1'b0;
        drive(1'b0, 1'b0, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(1'b1, 1'b0, 600);
        drive(1'b0, 1'b0, 0);
        sample();
        check("mid_rst_sof",  c_WW'(out_sof), c_WW'(1));
        check("mid_rst_data", out_word(), pix_word(600));
        drive(1'b0, 1'b1, 0);
        drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 0);
        sample();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
